// File: rtl/sub_bytes_sequencer.sv
// rtl/sub_bytes_sequencer.sv - AES SubBytes sequencer: LANES registered S-boxes, 16/LANES beats per block.
// Optional SUB_BYTES_BYPASS_EN adds a bypass input that returns the captured state unchanged.

module aes_sbox (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_byte <= 8'h00;
        end else begin
            out_byte <= SBOX[2047 - 8*in_byte -: 8];
        end
    end
endmodule

module sub_bytes_sequencer #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef SUB_BYTES_BYPASS_EN
    input  logic         bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     hold_q;
    logic [127:0]     result_q;
    logic [127:0]     result_nxt;
    logic [CNT_W-1:0] cap_beat;
    logic             cap_en;
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];
`ifdef SUB_BYTES_BYPASS_EN
    logic             bypass_q;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox u_sbox (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_byte  (lane_in[l]),
            .out_byte (lane_out[l])
        );
    end

    // Lanes idle at zero outside FEED; their outputs are never captured then.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = 8'h00;
        end
        if (state == FEED) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt == CNT_W'(b)) begin
                    for (int l = 0; l < LANES; l++) begin
                        lane_in[l] = hold_q[127 - 8*(b*LANES + l) -: 8];
                    end
                end
            end
        end
    end

    // S-box outputs trail their inputs by one cycle, so capture beat cnt-1 in FEED and the last beat in DRAIN.
    always_comb begin
        cap_en     = ((state == FEED) && (cnt != '0)) || (state == DRAIN);
        cap_beat   = (state == DRAIN) ? LAST_BEAT : (cnt - 1'b1);
        result_nxt = result_q;
        if (cap_en) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cap_beat == CNT_W'(b)) begin
                    for (int l = 0; l < LANES; l++) begin
                        result_nxt[127 - 8*(b*LANES + l) -: 8] = lane_out[l];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_q    <= '0;
            result_q  <= '0;
            out_valid <= 1'b0;
            out_state <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SUB_BYTES_BYPASS_EN
            bypass_q  <= 1'b0;
`endif
        end else begin
            if (cap_en) begin
                result_q <= result_nxt;
            end
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        hold_q   <= in_state;
`ifdef SUB_BYTES_BYPASS_EN
                        bypass_q <= bypass;
`endif
                        cnt      <= '0;
                        state    <= FEED;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                FEED: begin
                    if (cnt == LAST_BEAT) begin
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
`ifdef SUB_BYTES_BYPASS_EN
                    out_state <= bypass_q ? hold_q : result_nxt;
`else
                    out_state <= result_nxt;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// tb/tb_sub_bytes_sequencer.sv - bench for sub_bytes_sequencer at LANES=4, 1 and 16 with a GF(2^8) reference model.
module tb_sub_bytes_sequencer;
`ifdef SUB_BYTES_BYPASS_EN
    localparam bit HAS_BYP = 1'b1;
`else
    localparam bit HAS_BYP = 1'b0;
`endif
    localparam logic [127:0] T1V = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] T1E = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] T2E = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] in_state_a  [3];
    logic         byp_a       [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_state_a [3];
    logic         busy_a      [3];
    int           lat [3];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = sbox_ref(s[127 - 8*i -: 8]);
        end
        return r;
    endfunction

    function automatic int lat_of(input int g);
        case (g)
            0: return 6;
            1: return 18;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        localparam int BEATS_G = 16 / L;

        sub_bytes_sequencer #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_state  (in_state_a[g]),
`ifdef SUB_BYTES_BYPASS_EN
            .bypass    (byp_a[g]),
`endif
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );

        // Timeline model: t counts cycles since acceptance; result appears BEATS+2 cycles after it.
        int           t;
        bit           mv;
        logic [127:0] mo;
        logic [127:0] res;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                t = 0; mv = 1'b0; mo = '0;
            end else if (t == 0 && !mv) begin
                if (in_valid_a[g]) begin
                    res = (HAS_BYP && byp_a[g]) ? in_state_a[g] : sub_state(in_state_a[g]);
                    t = 1;
                end
            end else if (t > 0) begin
                if (t == BEATS_G + 1) begin
                    t = 0; mv = 1'b1; mo = res;
                end else begin
                    t++;
                end
            end else if (out_ready_a[g]) begin
                mv = 1'b0;
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                chk($sformatf("d%0d out_valid", g), 128'(out_valid_a[g]), 128'(mv));
                chk($sformatf("d%0d out_state", g), out_state_a[g], mo);
                chk($sformatf("d%0d in_ready", g), 128'(in_ready_a[g]), 128'(t == 0 && !mv));
                chk($sformatf("d%0d busy", g), 128'(busy_a[g]), 128'(t != 0 || mv));
            end
        end

        bit pend;
        int k;
        always @(negedge clk) begin
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    k++;
                    if (out_valid_a[g]) begin
                        lat[g] = k; pend = 1'b0;
                    end
                end
                if (in_valid_a[g] && in_ready_a[g]) begin
                    pend = 1'b1; k = 0;
                end
            end
        end
    end

    task automatic run_block(input int g, input logic [127:0] st, input bit byp, input int hold,
                             input bit lit, input logic [127:0] exp, input int elat);
        int n;
        @(posedge clk); #2;
        in_valid_a[g]  = 1'b1;
        in_state_a[g]  = st;
        byp_a[g]       = byp;
        out_ready_a[g] = (hold == 0) ? 1'($urandom % 2) : 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!in_ready_a[g] && n < 50);
        if (!in_ready_a[g]) begin
            checks++; errors++;
            $display("FAIL d%0d accept timeout: in_ready stayed %b, required 1", g, in_ready_a[g]);
        end
        @(posedge clk); #2;
        in_valid_a[g] = 1'b0;
        in_state_a[g] = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!out_valid_a[g] && n < 50) begin
            @(negedge clk); n++;
        end
        if (!out_valid_a[g]) begin
            checks++; errors++;
            $display("FAIL d%0d result timeout: out_valid stayed %b, required 1", g, out_valid_a[g]);
        end
        #1;
        if (lit) begin
            chk($sformatf("d%0d lit out_state", g), out_state_a[g], exp);
            chk($sformatf("d%0d lit latency", g), 128'(lat[g]), 128'(elat));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #2;
            in_valid_a[g] = 1'($urandom % 2);
            in_state_a[g] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (lit && hold > 0) begin
            chk($sformatf("d%0d held out_valid", g), 128'(out_valid_a[g]), 128'(1));
            chk($sformatf("d%0d held in_ready", g), 128'(in_ready_a[g]), 128'(0));
            chk($sformatf("d%0d held out_state", g), out_state_a[g], exp);
        end
        out_ready_a[g] = 1'b1;
        in_valid_a[g]  = 1'b0;
        @(posedge clk); #2;
        out_ready_a[g] = 1'b0;
        @(negedge clk);
        if (lit) chk($sformatf("d%0d in_ready after", g), 128'(in_ready_a[g]), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            in_valid_a[g] = 1'b0; in_state_a[g] = '0; byp_a[g] = 1'b0; out_ready_a[g] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("d%0d reset out_valid", g), 128'(out_valid_a[g]), 128'(0));
            chk($sformatf("d%0d reset out_state", g), out_state_a[g], 128'(0));
            chk($sformatf("d%0d reset in_ready", g), 128'(in_ready_a[g]), 128'(1));
            chk($sformatf("d%0d reset busy", g), 128'(busy_a[g]), 128'(0));
        end
        chk("model sbox(53)", 128'(sbox_ref(8'h53)), 128'(8'hed));
        chk("model T1", sub_state(T1V), T1E);

        for (int g = 0; g < 3; g++) run_block(g, T1V, 1'b0, 0, 1'b1, T1E, lat_of(g));
        run_block(0, '0, 1'b0, 0, 1'b1, T2E, 6);
        run_block(0, T1V, 1'b0, 5, 1'b1, T1E, 6);

        // Abort a block with reset while the beat counter is at 2.
        @(posedge clk); #2;
        in_valid_a[0] = 1'b1; in_state_a[0] = 128'hffeeddccbbaa99887766554433221100;
        @(posedge clk); #2;
        in_valid_a[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort out_valid", 128'(out_valid_a[0]), 128'(0));
        chk("abort out_state", out_state_a[0], 128'(0));
        chk("abort in_ready", 128'(in_ready_a[0]), 128'(1));
        chk("abort busy", 128'(busy_a[0]), 128'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        run_block(0, T1V, 1'b0, 0, 1'b1, T1E, 6);

`ifdef SUB_BYTES_BYPASS_EN
        run_block(0, T1V, 1'b1, 0, 1'b1, T1V, 6);
        run_block(2, T1V, 1'b1, 2, 1'b1, T1V, 3);
`endif

        for (int g = 0; g < 3; g++) begin
            run_block(g, {16{8'hff}}, 1'b0, 1, 1'b0, '0, 0);
            for (int i = 0; i < 12; i++) begin
                run_block(g, {$urandom, $urandom, $urandom, $urandom},
                          HAS_BYP ? 1'($urandom % 2) : 1'b0, $urandom_range(0, 3), 1'b0, '0, 0);
            end
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
